// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_pkg                                                       |
// | Description : Shared update-kind encodings, BTB entry type and counter     |
// |               init/saturation helpers for the fetch-stage predictor.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bp_pkg;

   localparam logic [1:0] BP_KIND_BR   = 2'b00;
   localparam logic [1:0] BP_KIND_JAL  = 2'b01;
   localparam logic [1:0] BP_KIND_JALR = 2'b10;
   localparam logic [1:0] BP_KIND_RSVD = 2'b11;

   // Tag, target and counter widths depend on instance parameters, so they live
   // in per-entry arrays beside this struct.
   typedef struct packed {
      logic valid;
      logic isJump;
   } bp_entry_t;

   function automatic int unsigned cntInit(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

   function automatic int unsigned cntMax(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_btb_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_btb_predictor_if                                          |
// | Description : Fetch lookup / execute update bundle of the BTB predictor.   |
// |               Perf-counter outputs exist only with BP_PERF_CNT_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bp_btb_predictor_if #(
   parameter int XLEN = 32
);
   logic            fetch_i_valid;
   logic [XLEN-1:0] fetch_i_pc;
   logic [XLEN-1:0] bp_o_pre_pc;
   logic            bp_o_taken;
   logic            bp_o_hit;
   logic            execute_i_upd_valid;
   logic [XLEN-1:0] execute_i_upd_pc;
   logic [XLEN-1:0] execute_i_upd_target;
   logic            execute_i_upd_taken;
   logic [1:0]      execute_i_upd_kind;
   logic            execute_i_upd_mispredict;
   logic            bp_i_flush;
`ifdef BP_PERF_CNT_EN
   logic [31:0]     bp_o_lookup_cnt;
   logic [31:0]     bp_o_upd_cnt;
   logic [31:0]     bp_o_mispred_cnt;
`endif

   modport master (
      output fetch_i_valid, fetch_i_pc,
      output execute_i_upd_valid, execute_i_upd_pc, execute_i_upd_target,
      output execute_i_upd_taken, execute_i_upd_kind, execute_i_upd_mispredict,
      output bp_i_flush,
`ifdef BP_PERF_CNT_EN
      input  bp_o_lookup_cnt, bp_o_upd_cnt, bp_o_mispred_cnt,
`endif
      input  bp_o_pre_pc, bp_o_taken, bp_o_hit
   );

   modport slave (
      input  fetch_i_valid, fetch_i_pc,
      input  execute_i_upd_valid, execute_i_upd_pc, execute_i_upd_target,
      input  execute_i_upd_taken, execute_i_upd_kind, execute_i_upd_mispredict,
      input  bp_i_flush,
`ifdef BP_PERF_CNT_EN
      output bp_o_lookup_cnt, bp_o_upd_cnt, bp_o_mispred_cnt,
`endif
      output bp_o_pre_pc, bp_o_taken, bp_o_hit
   );
endinterface
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_sat_counter                                               |
// | Description : CNT_W saturating up/down direction counter, weakly-taken     |
// |               on reset and on load.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_sat_counter
   import bp_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_load,
   input  wire logic i_step,
   input  wire logic i_up,
   output logic      o_msb
);
   localparam logic [CNT_W-1:0] C_INIT = CNT_W'(cntInit(CNT_W));
   localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(cntMax(CNT_W));

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= C_INIT;
      end else if (i_load) begin
         r_cnt <= C_INIT;
      end else if (i_step) begin
         if (i_up && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (!i_up && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign o_msb = r_cnt[CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/bp_btb_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_btb_predictor                                             |
// | Description : Direct-mapped BTB next-PC predictor, combinational lookup,   |
// |               edge-trained from execute. Optional BP_PERF_CNT_EN counters. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_btb_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   bp_btb_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   bp_entry_t        r_ent    [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [XLEN-1:0]  r_target [ENTRIES];
   logic             w_cntMsb [ENTRIES];

   logic [IDX_W-1:0] w_lkIdx, w_upIdx;
   logic [TAG_W-1:0] w_lkTag, w_upTag;
   logic             w_lkHit, w_lkTaken;
   logic             w_upHit, w_upEn, w_isJal, w_alloc, w_brStep, w_tgtWr;

   assign w_lkIdx   = bus.fetch_i_pc[IDX_W+1:2];
   assign w_lkTag   = bus.fetch_i_pc[XLEN-1:IDX_W+2];
   assign w_lkHit   = r_ent[w_lkIdx].valid && (r_tag[w_lkIdx] == w_lkTag);
   assign w_lkTaken = w_lkHit && (r_ent[w_lkIdx].isJump || w_cntMsb[w_lkIdx]);

   assign bus.bp_o_hit    = w_lkHit;
   assign bus.bp_o_taken  = w_lkTaken;
   assign bus.bp_o_pre_pc = w_lkTaken ? r_target[w_lkIdx] : bus.fetch_i_pc + XLEN'(4);

   assign w_upIdx  = bus.execute_i_upd_pc[IDX_W+1:2];
   assign w_upTag  = bus.execute_i_upd_pc[XLEN-1:IDX_W+2];
   assign w_upHit  = r_ent[w_upIdx].valid && (r_tag[w_upIdx] == w_upTag);
   assign w_isJal  = (bus.execute_i_upd_kind == BP_KIND_JAL);
   // Flush wins: a same-cycle update is discarded entirely.
   assign w_upEn   = bus.execute_i_upd_valid && !bus.bp_i_flush &&
                     ((bus.execute_i_upd_kind == BP_KIND_BR) || w_isJal);
   assign w_alloc  = w_upEn && !w_upHit && bus.execute_i_upd_taken;
   assign w_brStep = w_upEn && w_upHit && !w_isJal;
   assign w_tgtWr  = w_alloc || (w_upEn && w_upHit && (w_isJal || bus.execute_i_upd_taken));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
      end else if (bus.bp_i_flush) begin
         for (int i = 0; i < ENTRIES; i++) r_ent[i].valid <= 1'b0;
      end else if (w_alloc) begin
         r_ent[w_upIdx] <= '{valid: 1'b1, isJump: w_isJal};
      end else if (w_upEn && w_upHit && w_isJal) begin
         r_ent[w_upIdx].isJump <= 1'b1;
      end
   end

   // Payload is only meaningful behind a valid bit, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_alloc) r_tag[w_upIdx] <= w_upTag;
      if (w_tgtWr) r_target[w_upIdx] <= bus.execute_i_upd_target;
   end

   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_alloc && (w_upIdx == IDX_W'(i))),
         .i_step (w_brStep && (w_upIdx == IDX_W'(i))),
         .i_up   (bus.execute_i_upd_taken),
         .o_msb  (w_cntMsb[i])
      );
   end

   logic w_unusedPcBits;
   assign w_unusedPcBits = ^bus.execute_i_upd_pc[1:0];

`ifdef BP_PERF_CNT_EN
   logic [31:0] r_lookupCnt, r_updCnt, r_mispredCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lookupCnt  <= '0;
         r_updCnt     <= '0;
         r_mispredCnt <= '0;
      end else begin
         if (bus.fetch_i_valid) r_lookupCnt <= r_lookupCnt + 32'd1;
         if (bus.execute_i_upd_valid) r_updCnt <= r_updCnt + 32'd1;
         if (bus.execute_i_upd_valid && bus.execute_i_upd_mispredict)
            r_mispredCnt <= r_mispredCnt + 32'd1;
      end
   end

   assign bus.bp_o_lookup_cnt  = r_lookupCnt;
   assign bus.bp_o_upd_cnt     = r_updCnt;
   assign bus.bp_o_mispred_cnt = r_mispredCnt;
`else
   logic w_unusedPerfIn;
   assign w_unusedPerfIn = bus.fetch_i_valid ^ bus.execute_i_upd_mispredict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_btb_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_btb_predictor                                          |
// | Description : Directed vector bench for bp_btb_predictor (16 entries,      |
// |               2-bit counters); perf section under BP_PERF_CNT_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bp_btb_predictor;
   import bp_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bp_btb_predictor_if #(.XLEN(32)) bus ();

   bp_btb_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int nErr = 0;
   int nChk = 0;

   typedef struct {
      logic        upd;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
      logic [1:0]  kind;
      logic [31:0] look;
      logic        eHit;
      logic        eTaken;
      logic [31:0] ePre;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic u, input logic [31:0] pc, input logic [31:0] tgt,
                               input logic tk, input logic [1:0] kd, input logic [31:0] lk,
                               input logic eh, input logic et, input logic [31:0] ep);
      vec_t v;
      v.upd = u; v.pc = pc; v.tgt = tgt; v.taken = tk; v.kind = kd;
      v.look = lk; v.eHit = eh; v.eTaken = et; v.ePre = ep;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chkLook(input string nm, input logic eh, input logic et, input logic [31:0] ep);
      chk({nm, ".hit"}, {31'd0, bus.bp_o_hit}, {31'd0, eh});
      chk({nm, ".taken"}, {31'd0, bus.bp_o_taken}, {31'd0, et});
      chk({nm, ".pre_pc"}, bus.bp_o_pre_pc, ep);
   endtask

   task automatic setUpd(input logic u, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic [1:0] kd);
      bus.execute_i_upd_valid  = u;
      bus.execute_i_upd_pc     = pc;
      bus.execute_i_upd_target = tgt;
      bus.execute_i_upd_taken  = tk;
      bus.execute_i_upd_kind   = kd;
   endtask

   task automatic lookAt(input logic [31:0] pc);
      bus.fetch_i_pc = pc;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      bus.fetch_i_valid = 1'b0;
      bus.fetch_i_pc = 32'h8000_0000;
      bus.execute_i_upd_mispredict = 1'b0;
      bus.bp_i_flush = 1'b0;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);

      repeat (2) @(posedge clk);
      #1;
      chkLook("in_reset", 1'b0, 1'b0, 32'h8000_0004);
      rst = 1'b1;
      #1;
      chkLook("post_reset", 1'b0, 1'b0, 32'h8000_0004);

      // upd, pc, target, taken, kind, lookup pc, expected hit/taken/pre_pc
      vq.push_back(mk(0, 32'h8000_0000, 0, 0, BP_KIND_BR, 32'h8000_0000, 0, 0, 32'h8000_0004));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 1, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0040));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 0, BP_KIND_BR, 32'h8000_0010, 1, 0, 32'h8000_0014));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 0, BP_KIND_BR, 32'h8000_0010, 1, 0, 32'h8000_0014));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 1, BP_KIND_BR, 32'h8000_0010, 1, 0, 32'h8000_0014));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 1, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0040));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 1, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0040));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 1, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0040));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 0, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0040));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0040, 0, BP_KIND_BR, 32'h8000_0010, 1, 0, 32'h8000_0014));
      vq.push_back(mk(1, 32'h8000_0010, 32'h8000_0080, 1, BP_KIND_BR, 32'h8000_0010, 1, 1, 32'h8000_0080));
      vq.push_back(mk(1, 32'h8000_0050, 32'h8000_1000, 1, BP_KIND_JAL, 32'h8000_0010, 0, 0, 32'h8000_0014));
      vq.push_back(mk(0, 32'h8000_0050, 0, 0, BP_KIND_BR, 32'h8000_0050, 1, 1, 32'h8000_1000));
      vq.push_back(mk(1, 32'h8000_0050, 32'h8000_2000, 0, BP_KIND_BR, 32'h8000_0050, 1, 1, 32'h8000_1000));
      vq.push_back(mk(1, 32'h8000_0050, 32'h8000_2000, 0, BP_KIND_BR, 32'h8000_0050, 1, 1, 32'h8000_1000));
      vq.push_back(mk(1, 32'h8000_0020, 32'h9000_0000, 1, BP_KIND_JALR, 32'h8000_0020, 0, 0, 32'h8000_0024));
      vq.push_back(mk(1, 32'h8000_0030, 32'h9000_0000, 1, BP_KIND_RSVD, 32'h8000_0030, 0, 0, 32'h8000_0034));
      vq.push_back(mk(1, 32'h8000_0024, 32'h9000_0000, 0, BP_KIND_BR, 32'h8000_0024, 0, 0, 32'h8000_0028));
      vq.push_back(mk(1, 32'h8000_0000, 32'h8000_0100, 1, BP_KIND_JAL, 32'h8000_0000, 1, 1, 32'h8000_0100));
      vq.push_back(mk(0, 32'h0, 0, 0, BP_KIND_BR, 32'hFFFF_FFFC, 0, 0, 32'h0000_0000));

      for (int i = 0; i < vq.size(); i++) begin
         setUpd(vq[i].upd, vq[i].pc, vq[i].tgt, vq[i].taken, vq[i].kind);
         @(posedge clk);
         #1;
         setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
         lookAt(vq[i].look);
         chkLook($sformatf("vec%0d", i), vq[i].eHit, vq[i].eTaken, vq[i].ePre);
      end

      // Same-index lookup during an update sees the old contents.
      lookAt(32'h8000_0010);
      setUpd(1'b1, 32'h8000_0010, 32'h8000_0040, 1'b1, BP_KIND_BR);
      #1;
      chkLook("nobypass_before", 1'b0, 1'b0, 32'h8000_0014);
      @(posedge clk);
      #1;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
      #1;
      chkLook("nobypass_after", 1'b1, 1'b1, 32'h8000_0040);

      // Flush with a same-cycle allocating update.
      setUpd(1'b1, 32'h8000_0044, 32'h8000_0200, 1'b1, BP_KIND_BR);
      bus.bp_i_flush = 1'b1;
      @(posedge clk);
      #1;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
      bus.bp_i_flush = 1'b0;
      lookAt(32'h8000_0044);
      chkLook("flush_drop", 1'b0, 1'b0, 32'h8000_0048);
      lookAt(32'h8000_0010);
      chkLook("flush_idx4", 1'b0, 1'b0, 32'h8000_0014);
      lookAt(32'h8000_0000);
      chkLook("flush_idx0", 1'b0, 1'b0, 32'h8000_0004);

      // Asynchronous reset between edges, then an update lost under reset.
      setUpd(1'b1, 32'h8000_0060, 32'h8000_0300, 1'b1, BP_KIND_BR);
      @(posedge clk);
      #1;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
      lookAt(32'h8000_0060);
      chkLook("pre_async", 1'b1, 1'b1, 32'h8000_0300);
      rst = 1'b0;
      #1;
      chkLook("async_rst", 1'b0, 1'b0, 32'h8000_0064);
      setUpd(1'b1, 32'h8000_0070, 32'h8000_0400, 1'b1, BP_KIND_BR);
      @(posedge clk);
      #1;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
      rst = 1'b1;
      lookAt(32'h8000_0070);
      chkLook("rst_mid_upd", 1'b0, 1'b0, 32'h8000_0074);
      lookAt(32'h8000_0060);
      chkLook("rst_cleared", 1'b0, 1'b0, 32'h8000_0064);

`ifdef BP_PERF_CNT_EN
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.fetch_i_valid = 1'b1;
         setUpd(k < 3, 32'h8000_0020, 32'h9000_0000, 1'b1, BP_KIND_JALR);
         bus.execute_i_upd_mispredict = (k == 1);
         @(posedge clk);
         #1;
      end
      bus.fetch_i_valid = 1'b0;
      bus.execute_i_upd_mispredict = 1'b0;
      setUpd(1'b0, '0, '0, 1'b0, BP_KIND_BR);
      #1;
      chk("perf_lookup", bus.bp_o_lookup_cnt, 32'd5);
      chk("perf_upd", bus.bp_o_upd_cnt, 32'd3);
      chk("perf_mispred", bus.bp_o_mispred_cnt, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("perf_rst_lookup", bus.bp_o_lookup_cnt, 32'd0);
      chk("perf_rst_upd", bus.bp_o_upd_cnt, 32'd0);
      chk("perf_rst_mispred", bus.bp_o_mispred_cnt, 32'd0);
      rst = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bp_btb_predictor.md
Name: bp_btb_predictor

Overview:
- Parametrised next-PC predictor for the fetch stage; replaces the static pc+4 next-PC guess.
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Lookup is combinational on the current fetch PC and drives the predicted PC into select_pc/regD.
- Trained on the clock edge from resolved control-flow results in execute.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entries; power of two, >=2; IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width; >=1.
- TAG_W, XLEN-IDX_W-2, stored tag width (pc[XLEN-1:IDX_W+2]).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_i_valid  in  1  fetch PC is live this cycle (low during regF stall).
- fetch_i_pc  in  XLEN  current fetch PC.
- bp_o_pre_pc  out  XLEN  predicted next PC.
- bp_o_taken  out  1  prediction is taken.
- bp_o_hit  out  1  BTB tag hit.
- execute_i_upd_valid  in  1  resolved control-flow instruction in execute.
- execute_i_upd_pc  in  XLEN  PC of the resolved instruction.
- execute_i_upd_target  in  XLEN  resolved target.
- execute_i_upd_taken  in  1  actual direction.
- execute_i_upd_kind  in  2  00 cond branch, 01 jal, 10 jalr, 11 reserved (ignored).
- execute_i_upd_mispredict  in  1  execute flushed on this instruction.
- bp_i_flush  in  1  synchronous invalidate of all entries (fence.i).

Behaviour:
- Entry fields: valid, tag, target, is_jump, cnt[CNT_W].
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - taken = hit & (is_jump | cnt MSB).
  - pre_pc = taken ? target : fetch_i_pc+4. The +4 wraps modulo 2^XLEN.
  - Outputs are defined even when fetch_i_valid is low; fetch_i_valid only gates the perf counters.
- Update (rising edge, when upd_valid and kind != 10/11):
  - Hit on upd_pc:
    - Branch: cnt saturating +1 if taken, -1 if not (clamped at 0 and 2^CNT_W-1).
    - Target overwritten when taken.
    - Jal: target refreshed, is_jump=1.
  - Miss: allocate only if taken.
    - Write valid=1, tag, target, is_jump=(kind==01), cnt=2^(CNT_W-1) (weakly taken).
    - Replaces any existing occupant of the index.
  - Miss and not taken: no state change.
  - jalr and reserved kinds never allocate or modify entries.
- Simultaneous lookup/update to the same index: lookup returns pre-update contents (no bypass).
- bp_i_flush: clears every valid bit at the next edge. It takes priority over a same-cycle update, which is dropped.
- Reset (rst low, asynchronous):
  - All valid bits 0 and counters cleared to 2^(CNT_W-1). Tags/targets need no reset.
  - Outputs during/after reset: bp_o_hit=0, bp_o_taken=0, bp_o_pre_pc=fetch_i_pc+4.
  - Reset mid-update: the update is lost.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all reset to 0 and wrapping at 2^32:
  - bp_o_lookup_cnt: increments when fetch_i_valid.
  - bp_o_upd_cnt: increments on every upd_valid, including jalr.
  - bp_o_mispred_cnt: increments on upd_valid & upd_mispredict.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - upd_kind encoding constants (BP_KIND_BR, BP_KIND_JAL, BP_KIND_JALR).
  - Entry struct typedef.
  - Counter init/saturation helper functions.
- Sub-module bp_sat_counter: a CNT_W saturating up/down counter, instantiated per entry.

Test Plan (ENTRIES=16, CNT_W=2):
- Reset then lookup pc=0x80000000 -> hit=0, taken=0, pre_pc=0x80000004.
- Update branch pc=0x80000010 taken, target 0x80000040; next cycle lookup 0x80000010 -> hit=1, taken=1, pre_pc=0x80000040.
- Same entry, two not-taken updates -> cnt 10->01->00, lookup taken=0, pre_pc=0x80000014. Three taken updates -> cnt 11 saturated, a fourth taken update leaves 11.
- Alias pc=0x80000050 (same index 4, different tag) jal taken, target 0x80001000 -> replaces entry; lookup 0x80000010 hit=0; lookup 0x80000050 taken=1 regardless of cnt.
- jalr update pc=0x80000020 taken -> no allocation, lookup hit=0. Update with bp_i_flush in the same cycle -> all entries invalid, update dropped.
- BP_PERF_CNT_EN: 5 valid fetches, 3 updates of which 1 mispredict -> counts 5/3/1. Assert rst low mid-run -> all counters 0 asynchronously.
